// File: rtl/ne_pkg.sv
// Shared types and helpers for the bit-serial not-equal evaluator.
// State encoding and the index-width function used by ne_bitserial.
package ne_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  function automatic int ne_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ne_nbit.sv
// Parallel N-bit not-equal compare.
// Used per slice by the bit-serial evaluator.
module ne_nbit #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ne
);

  assign ne = |(a ^ b);

endmodule

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder with found flag.
// Only instantiated when NE_FIRST_IDX_EN is defined.
import ne_pkg::*;

module prio_enc_lsb #(
  parameter int WIDTH = 1,
  localparam int PW = ne_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [PW-1:0]    idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = PW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ne_bitserial.sv
// Bit-serial A != B evaluator, LSB slice first, valid/ready in and out.
// Define NE_FIRST_IDX_EN to also report the lowest mismatching bit index.
import ne_pkg::*;

module ne_bitserial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1,
  localparam int BEATS = WIDTH / SLICE,
  localparam int IDXW = ne_clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SLICE-1:0] in_a,
  input  logic [SLICE-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ne,
  output logic [IDXW-1:0]  out_idx
);

  localparam int CW = ne_clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("ne_bitserial: WIDTH must be a multiple of SLICE");
  end

  state_e        state;
  logic [CW-1:0] beat_cnt;
  logic          ne_acc;
  logic          slice_ne;
  logic          accept;
  logic          last;
  logic          pop;

  ne_nbit #(.WIDTH(SLICE)) u_cmp (
    .a  (in_a),
    .b  (in_b),
    .ne (slice_ne)
  );

  assign in_ready = !flush && (state == S_ACC || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (beat_cnt == LAST);
  assign pop      = (state == S_OUT) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ACC;
      beat_cnt  <= '0;
      ne_acc    <= 1'b0;
      out_valid <= 1'b0;
      out_ne    <= 1'b0;
    end else begin
      if (flush) begin
        beat_cnt <= '0;
        ne_acc   <= 1'b0;
      end
      if (pop) begin
        state     <= S_ACC;
        out_valid <= 1'b0;
      end
      // a beat taken alongside a pop starts the next pair
      if (accept) begin
        if (last) begin
          out_ne    <= ne_acc | slice_ne;
          out_valid <= 1'b1;
          state     <= S_OUT;
          beat_cnt  <= '0;
          ne_acc    <= 1'b0;
        end else begin
          ne_acc   <= ne_acc | slice_ne;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef NE_FIRST_IDX_EN
  localparam int PW = ne_clog2(SLICE);

  logic [PW-1:0]   pidx;
  logic            pfound;
  logic [IDXW-1:0] idx_acc;
  logic [IDXW-1:0] cur_pos;

  prio_enc_lsb #(.WIDTH(SLICE)) u_enc (
    .vec   (in_a ^ in_b),
    .idx   (pidx),
    .found (pfound)
  );

  assign cur_pos = IDXW'(int'(beat_cnt) * SLICE + int'(pidx));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_acc <= '0;
      out_idx <= '0;
    end else begin
      if (flush) idx_acc <= '0;
      if (accept) begin
        if (last) begin
          idx_acc <= '0;
          if (ne_acc)      out_idx <= idx_acc;
          else if (pfound) out_idx <= cur_pos;
          else             out_idx <= '0;
        end else if (!ne_acc && pfound) begin
          idx_acc <= cur_pos;
        end
      end
    end
  end
`else
  assign out_idx = '0;
`endif

endmodule
